mux4_rr_arbiter: RTL

Round-robin arbiter that shares the 4-to-1 single-bit mux between four requesters. It drives the mux select lines `s1`/`s0` and returns a one-hot grant to the requesters. Each grant lasts a bounded number of cycles, and a dead cycle separates consecutive owners. It sits between the requester logic and the `a`/`b`/`c`/`d` inputs of the 4-to-1 mux instance.

---
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for a shared 4-to-1 mux.
// Each grant lasts at most HOLD_MAX cycles, and one dead cycle separates owners.
// Ports:
//   clk      - clock, all state updates on posedge
//   rst      - asynchronous active-high reset
//   req      - level requests; bit i selects mux input a/b/c/d
//   gnt      - registered one-hot grant, 0000 when there is no owner
//   valid    - high while gnt is nonzero
//   s1, s0   - mux select, the index of the current or most recent owner
//   timeout  - one-cycle pulse in the GAP cycle that follows a HOLD_MAX expiry
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       s1,
  output logic       s0,
  output logic       timeout
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [IDX_W-1:0]  win;
  logic              rel;

  // Round-robin search: walking from ptr+3 down to ptr lets the closest hit win.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[IDX_W'(ptr_q + IDX_W'(k))]) begin
        found = 1'b1;
        win   = IDX_W'(ptr_q + IDX_W'(k));
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    rel       = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          owner_d = win;
          gnt_d   = 4'(4'b0001 << win);
          valid_d = 1'b1;
          sel_d   = win;
          cnt_d   = '0;
          ptr_d   = IDX_W'(win + IDX_W'(1));
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A dropped request takes priority over expiry, so no timeout then.
        if (!req[owner_q]) begin
          rel = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
        if (rel) begin
          state_d = GAP;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign valid   = valid_q;
  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign timeout = timeout_q;

endmodule
